raymarch_frame_sequencer: RTL
=============================

// Module: raymarch_frame_sequencer
// PURPOSE
//  Drives the raymarcher across a full WIDTH x HEIGHT frame in raster order: presents pixel
//  coordinates on curr_x/curr_y, waits for pixel_done, captures out_x/out_y and RGB, and
//  writes packed 24-bit colour into the framebuffer write port at y*WIDTH+x. Sits between
//  the frame-control logic and the raymarcher/framebuffer. Replaces bench-style hand driving.
// PARAMETERS
//  WIDTH           300    pixels per line
//  HEIGHT          300    lines per frame
//  COORD_W         33     width of coordinate buses (matches raymarcher curr_x/out_x)
//  ADDR_W          17     framebuffer address width; must hold WIDTH*HEIGHT-1
//  TIMEOUT_CYCLES  65535  max cycles waiting for pixel_done before forcing error pixel
// PORTS
//  clk_in         in   1        system clock
//  rst_in         in   1        asynchronous, active-low reset
//  frame_start_in in   1        1-cycle pulse: begin frame (ignored unless IDLE)
//  curr_x_out     out  COORD_W  x coordinate presented to raymarcher
//  curr_y_out     out  COORD_W  y coordinate presented to raymarcher
//  rm_start_out   out  1        1-cycle pulse when new coordinate is presented
//  pixel_done_in  in   1        raymarcher result valid (1-cycle pulse)
//  out_x_in       in   COORD_W  raymarcher echoed x
//  out_y_in       in   COORD_W  raymarcher echoed y
//  red_in/green_in/blue_in in 8 each  raymarcher colour
//  fb_we_out      out  1        framebuffer write enable
//  fb_addr_out    out  ADDR_W   framebuffer address
//  fb_data_out    out  24       {red,green,blue}
//  fb_ready_in    in   1        framebuffer accepts write this cycle when high
//  busy_out       out  1        high from ISSUE through last write
//  frame_done_out out  1        1-cycle pulse after last pixel written
//  mismatch_out   out  1        sticky: echoed coords differed from issued
//  timeout_out    out  1        sticky: a pixel hit TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (rst_in low, async): state IDLE; x=y=0; all outputs 0; sticky flags cleared.
//  States: IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | DONE) -> IDLE.
//  IDLE: frame_start_in high -> ISSUE next edge; clears mismatch_out/timeout_out.
//  ISSUE (1 cycle): curr_x/y_out = x,y (held stable until next ISSUE); rm_start_out=1;
//    timeout counter cleared; -> WAIT.
//  WAIT: on pixel_done_in, latch RGB and echoed coords; if out_x_in!=x or out_y_in!=y set
//    mismatch_out (address still uses issued x,y); -> WRITE. pixel_done_in in any other
//    state is ignored. Counter reaches TIMEOUT_CYCLES without done -> latch 24'hFF00FF,
//    set timeout_out, -> WRITE. Done and timeout same cycle: done wins.
//  WRITE: fb_we_out=1, fb_addr_out=y*WIDTH+x, fb_data_out=latched colour; held until
//    fb_ready_in high (write completes that edge). Then x increments; x==WIDTH-1 wraps to 0
//    and y increments; last pixel (WIDTH-1,HEIGHT-1) -> DONE, else -> ISSUE.
//  DONE (1 cycle): frame_done_out=1, busy_out=0 -> IDLE. x,y reset to 0.
//  Address: y*WIDTH+x computed by running base register (+WIDTH per line), no multiplier.
//  Minimum per-pixel cost: 3 cycles + raymarcher latency.
//  frame_start_in while busy: ignored. Reset mid-frame: aborts immediately, no fb write.
// TESTING
//  WIDTH=4,HEIGHT=3, model returns done 5 cyc after rm_start, RGB={x,y,0x55} -> 12 writes,
//    addrs 0..11 in order, data matches, one frame_done pulse, flags 0.
//  fb_ready_in low for 3 cycles on addr 5 -> we/addr/data held stable, no skipped or
//    duplicated write, x,y advance only after ready.
//  Model echoes out_x=x+1 on pixel (2,1) -> mismatch_out set and stays set; write goes to
//    addr 6; cleared on next frame_start_in.
//  TIMEOUT_CYCLES=16, model never answers pixel (0,0) -> write 24'hFF00FF at addr 0 after
//    16 WAIT cycles, timeout_out=1, frame continues.
//  Assert rst_in low in WAIT of pixel 7 -> outputs 0 immediately; new frame restarts at 0.
//  frame_start_in pulsed mid-frame and pixel_done_in during WRITE -> both ignored.

Source files
------------

// File: rtl/raymarch_frame_sequencer.sv
// Raster-order frame sequencer: issues pixel coordinates to the raymarcher,
// collects each result (or a magenta error pixel on timeout) and writes the
// packed colour to the framebuffer at y*WIDTH+x.
module raymarch_frame_sequencer #(
  parameter int WIDTH          = 300,
  parameter int HEIGHT         = 300,
  parameter int COORD_W        = 33,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start_in,
  output logic [COORD_W-1:0] curr_x_out,
  output logic [COORD_W-1:0] curr_y_out,
  output logic               rm_start_out,
  input  logic               pixel_done_in,
  input  logic [COORD_W-1:0] out_x_in,
  input  logic [COORD_W-1:0] out_y_in,
  input  logic [7:0]         red_in,
  input  logic [7:0]         green_in,
  input  logic [7:0]         blue_in,
  output logic               fb_we_out,
  output logic [ADDR_W-1:0]  fb_addr_out,
  output logic [23:0]        fb_data_out,
  input  logic               fb_ready_in,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               mismatch_out,
  output logic               timeout_out
);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [23:0] ERR_COLOUR = 24'hFF00FF;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [XW-1:0]       x, x_adv;
  logic [YW-1:0]       y, y_adv;
  logic [ADDR_W-1:0]   row_base, base_adv;   // y*WIDTH kept as a running sum
  logic [TW-1:0]       tmo_cnt;
  logic [23:0]         col_q;
  logic [COORD_W-1:0]  pres_x, pres_y;       // coordinate held for the raymarcher
  logic                last_col, last_row, echo_bad, tmo_hit;

  // Raster-advance helpers and result qualifiers
  always_comb begin
    last_col = (x == XW'(WIDTH - 1));
    last_row = (y == YW'(HEIGHT - 1));
    echo_bad = (out_x_in != COORD_W'(x)) || (out_y_in != COORD_W'(y));
    tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    if (last_col) begin
      x_adv    = '0;
      y_adv    = y + YW'(1);
      base_adv = row_base + ADDR_W'(WIDTH);
    end else begin
      x_adv    = x + XW'(1);
      y_adv    = y;
      base_adv = row_base;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and control outputs
  always_comb begin
    state_nxt      = state;
    rm_start_out   = 1'b0;
    fb_we_out      = 1'b0;
    busy_out       = 1'b0;
    frame_done_out = 1'b0;
    case (state)
      S_IDLE:  if (frame_start_in) state_nxt = S_ISSUE;
      S_ISSUE: begin
        rm_start_out = 1'b1;
        busy_out     = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        busy_out = 1'b1;
        if (pixel_done_in || tmo_hit) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy_out  = 1'b1;
        fb_we_out = 1'b1;
        if (fb_ready_in) state_nxt = (last_col && last_row) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        frame_done_out = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port only shows address/data while a write is pending
  assign fb_addr_out = fb_we_out ? (row_base + ADDR_W'(x)) : '0;
  assign fb_data_out = fb_we_out ? col_q : '0;
  assign curr_x_out  = pres_x;
  assign curr_y_out  = pres_y;

  // Datapath: coordinates, row base, timeout counter, colour latch, sticky flags
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x            <= '0;
      y            <= '0;
      row_base     <= '0;
      tmo_cnt      <= '0;
      col_q        <= '0;
      pres_x       <= '0;
      pres_y       <= '0;
      mismatch_out <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (frame_start_in) begin
          mismatch_out <= 1'b0;
          timeout_out  <= 1'b0;
          pres_x       <= COORD_W'(x);
          pres_y       <= COORD_W'(y);
        end
        S_ISSUE: tmo_cnt <= '0;
        S_WAIT: begin
          // A real result beats a timeout landing on the same cycle
          if (pixel_done_in) begin
            col_q <= {red_in, green_in, blue_in};
            if (echo_bad) mismatch_out <= 1'b1;
          end else if (tmo_hit) begin
            col_q       <= ERR_COLOUR;
            timeout_out <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_WRITE: if (fb_ready_in) begin
          if (last_col && last_row) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
          end else begin
            x        <= x_adv;
            y        <= y_adv;
            row_base <= base_adv;
            pres_x   <= COORD_W'(x_adv);
            pres_y   <= COORD_W'(y_adv);
          end
        end
        S_DONE: begin
          x        <= '0;
          y        <= '0;
          row_base <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
